// File: rtl/fpu_op_scheduler_if.sv
// Request/unit/response bundle between the FPU command side, the arithmetic units and the scheduler.
// Latency: none (wires only).
// Backpressure: req_valid/req_ready on the request side, resp_valid/resp_ready on the response side.
//
// Ports (signals):
//   req_valid/req_ready/req_a/req_b/req_opcode : request handshake and operands
//   unit_start/unit_a/unit_b                    : one-hot start pulse and registered operands to units
//   unit_done/res_add/res_sub/res_mul/res_div   : per-unit done pulses and results
//   resp_valid/resp_ready/resp_result/resp_opcode/resp_timeout : response handshake and payload
//   busy                                        : scheduler not idle
// Modports: slave = scheduler side, master = command/unit/consumer side.
interface fpu_op_scheduler_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 2
);
    logic                  req_valid;
    logic                  req_ready;
    logic [DATA_WIDTH-1:0] req_a;
    logic [DATA_WIDTH-1:0] req_b;
    logic [OP_WIDTH-1:0]   req_opcode;

    logic [3:0]            unit_start;
    logic [DATA_WIDTH-1:0] unit_a;
    logic [DATA_WIDTH-1:0] unit_b;
    logic [3:0]            unit_done;
    logic [DATA_WIDTH-1:0] res_add;
    logic [DATA_WIDTH-1:0] res_sub;
    logic [DATA_WIDTH-1:0] res_mul;
    logic [DATA_WIDTH-1:0] res_div;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_result;
    logic [OP_WIDTH-1:0]   resp_opcode;
    logic                  resp_timeout;

    logic                  busy;

    modport slave (
        input  req_valid, req_a, req_b, req_opcode,
        output req_ready,
        output unit_start, unit_a, unit_b,
        input  unit_done, res_add, res_sub, res_mul, res_div,
        output resp_valid, resp_result, resp_opcode, resp_timeout,
        input  resp_ready,
        output busy
    );

    modport master (
        output req_valid, req_a, req_b, req_opcode,
        input  req_ready,
        input  unit_start, unit_a, unit_b,
        output unit_done, res_add, res_sub, res_mul, res_div,
        input  resp_valid, resp_result, resp_opcode, resp_timeout,
        output resp_ready,
        input  busy
    );
endinterface

// File: rtl/fpu_op_scheduler.sv
// Sequences one FP op at a time: accept request, pulse start to the opcode-selected unit, wait for done or timeout, return result.
// Latency: accept at edge T -> start in cycle T+1 -> earliest done T+2 -> resp_valid from T+3; one op per 4 cycles at best.
// Backpressure: req_ready only in IDLE; response held stable in RESP until resp_ready, indefinitely if needed.
//
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous reset, active-high; aborts any op in flight without a response
//   bus  : fpu_op_scheduler_if.slave (request, unit start/done/results, response, busy)
module fpu_op_scheduler #(
    parameter int DATA_WIDTH     = 32,
    parameter int OP_WIDTH       = 2,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_WIDTH      = 7
) (
    input  logic                clk,
    input  logic                rst,
    fpu_op_scheduler_if.slave   bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [1:0]            state_q,   state_d;
    logic [OP_WIDTH-1:0]   op_q,      op_d;
    logic [DATA_WIDTH-1:0] a_q,       a_d;
    logic [DATA_WIDTH-1:0] b_q,       b_d;
    logic [CNT_WIDTH-1:0]  cnt_q,     cnt_d;
    logic [DATA_WIDTH-1:0] result_q,  result_d;
    logic                  timeout_q, timeout_d;

    logic                  done_sel;
    logic [DATA_WIDTH-1:0] res_sel;

    // Only the done bit of the unit that was actually started counts.
    assign done_sel = bus.unit_done[op_q];

    always_comb begin
        res_sel = bus.res_add;
        case (op_q)
            OP_WIDTH'(0): res_sel = bus.res_add;
            OP_WIDTH'(1): res_sel = bus.res_sub;
            OP_WIDTH'(2): res_sel = bus.res_mul;
            default:      res_sel = bus.res_div;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    op_d    = bus.req_opcode;
                    a_d     = bus.req_a;
                    b_d     = bus.req_b;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
                // done takes priority over a timeout landing in the same cycle
                if (done_sel) begin
                    result_d  = res_sel;
                    timeout_d = 1'b0;
                    state_d   = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    result_d  = '0;
                    timeout_d = 1'b1;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            timeout_q <= timeout_d;
        end
    end

    // req_ready is gated by rst so nothing is accepted on a reset edge.
    assign bus.req_ready    = (state_q == S_IDLE) && !rst;
    assign bus.unit_start   = (state_q == S_ISSUE) ? (4'b0001 << op_q) : 4'b0000;
    assign bus.unit_a       = a_q;
    assign bus.unit_b       = b_q;
    assign bus.resp_valid   = (state_q == S_RESP);
    assign bus.resp_result  = result_q;
    assign bus.resp_opcode  = op_q;
    assign bus.resp_timeout = timeout_q;
    assign bus.busy         = (state_q != S_IDLE);

endmodule
